// File: rtl/pc_channel_fifo.sv
// pc_channel_fifo: FWFT circular buffer carrying {pc, cc_id} between engines.
// Ports: clk, rst (sync, active-low), flush, in_valid/in_data/in_ready,
//        out_valid/out_data/out_ready, out_latency, count, max_count, clear_max.
module pc_channel_fifo #(
    parameter int PC_WIDTH            = 8,
    parameter int CC_ID_BITS          = 1,
    parameter int LATENCY_COUNT_WIDTH = 8,
    parameter int FIFO_COUNT_WIDTH    = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic [PC_WIDTH+CC_ID_BITS-1:0]      in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [PC_WIDTH+CC_ID_BITS-1:0]      out_data,
    input  logic                                out_ready,
    output logic [LATENCY_COUNT_WIDTH-1:0]      out_latency,
    output logic [FIFO_COUNT_WIDTH:0]           count,
    output logic [FIFO_COUNT_WIDTH:0]           max_count,
    input  logic                                clear_max
);

    localparam int DW    = PC_WIDTH + CC_ID_BITS;
    localparam int PW    = FIFO_COUNT_WIDTH;
    localparam int CW    = FIFO_COUNT_WIDTH + 1;
    localparam int DEPTH = 2 ** FIFO_COUNT_WIDTH;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] max_q;
    logic [CW-1:0] max_nxt;
    logic          push;
    logic          pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];
    assign count     = count_q;
    assign max_count = max_q;

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // clear_max reloads from the upcoming occupancy so the
    // watermark never reads below what count is showing.
    always_comb begin
        max_nxt = max_q;
        if (clear_max) begin
            max_nxt = count_nxt;
        end else if (count_nxt > max_q) begin
            max_nxt = count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_nxt;
            max_q   <= max_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is not reset; contents are only observed when out_valid.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    generate
        if (LATENCY_COUNT_WIDTH >= CW) begin : g_lat_wide
            assign out_latency = LATENCY_COUNT_WIDTH'(count_q);
        end else begin : g_lat_sat
            localparam int LAT_MAX = 2 ** LATENCY_COUNT_WIDTH - 1;
            assign out_latency = (count_q > CW'(LAT_MAX)) ? '1
                               : count_q[LATENCY_COUNT_WIDTH-1:0];
        end
    endgenerate

endmodule
